// File: rtl/can_rx_filter_fifo.sv
// CAN receive buffer: ID/mask acceptance filters feeding a small frame FIFO,
// with overrun counting and level-threshold interrupt behind a register bus.
module can_rx_filter_fifo #(
  parameter int NFILT = 4,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] d,
  output logic [31:0] q,
  input  logic        in_valid,
  input  logic [28:0] in_id,
  input  logic        in_ext,
  input  logic        in_rtr,
  input  logic [3:0]  in_dlc,
  input  logic [63:0] in_data,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic        ext;
    logic        rtr;
    logic [28:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [2:0]  hit;
  } entry_t;

  logic          stg_vld_q;
  entry_t        stg_q;
  entry_t        mem_q [DEPTH];

  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    ovr_cnt_q, ovr_cnt_d;
  logic          ovr_flag_q, ovr_flag_d;

  logic          acc_all_q, irq_en_q, ovr_irq_en_q;
  logic [3:0]    thresh_q;

  logic          flt_en_q   [NFILT];
  logic          flt_extv_q [NFILT];
  logic          flt_extdc_q[NFILT];
  logic [28:0]   flt_id_q   [NFILT];
  logic [28:0]   flt_mask_q [NFILT];

  logic       ctrl_wr, pop, flush, clr;
  logic       full, empty, accept, wr_en, ovr;
  logic       hit_found;
  logic [2:0] hit_idx;
  entry_t     head;
  logic [3:0] thr;

  assign ctrl_wr = cs & we & (addr == 5'd0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop     = ctrl_wr & d[0] & ~empty;
  assign flush   = ctrl_wr & d[1];
  assign clr     = ctrl_wr & d[2];
  assign head    = mem_q[rp_q];

  // Descending scan so the lowest-index match is the one left standing.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = 3'd7;
    for (int k = NFILT - 1; k >= 0; k--) begin
      if (flt_en_q[k] &&
          (((stg_q.id ^ flt_id_q[k]) & flt_mask_q[k]) == 29'd0) &&
          (flt_extdc_q[k] || (flt_extv_q[k] == stg_q.ext))) begin
        hit_found = 1'b1;
        hit_idx   = 3'(k);
      end
    end
  end

  assign accept = stg_vld_q & (hit_found | acc_all_q);

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    cnt_d      = cnt_q;
    ovr_cnt_d  = ovr_cnt_q;
    ovr_flag_d = ovr_flag_q;
    wr_en      = 1'b0;
    ovr        = accept & full & ~pop & ~flush;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (accept & (~full | pop)) begin
        wr_en = 1'b1;
        wp_d  = wp_q + AW'(1);
      end
      if (pop) rp_d = rp_q + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
    // A same-edge overrun survives the clear as a fresh count of one.
    if (clr) begin
      ovr_cnt_d  = ovr ? 8'd1 : 8'd0;
      ovr_flag_d = ovr;
    end else if (ovr) begin
      ovr_flag_d = 1'b1;
      if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_vld_q    <= 1'b0;
      stg_q        <= '0;
      wp_q         <= '0;
      rp_q         <= '0;
      cnt_q        <= '0;
      ovr_cnt_q    <= '0;
      ovr_flag_q   <= 1'b0;
      acc_all_q    <= 1'b1;
      irq_en_q     <= 1'b0;
      ovr_irq_en_q <= 1'b0;
      thresh_q     <= '0;
    end else begin
      stg_vld_q  <= in_valid;
      if (in_valid) begin
        stg_q <= '{ext: in_ext, rtr: in_rtr, id: in_id,
                   dlc: in_dlc, data: in_data, hit: 3'd0};
      end
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      ovr_cnt_q  <= ovr_cnt_d;
      ovr_flag_q <= ovr_flag_d;
      if (ctrl_wr) begin
        acc_all_q    <= d[3];
        irq_en_q     <= d[4];
        ovr_irq_en_q <= d[5];
        thresh_q     <= d[11:8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NFILT; k++) begin
        flt_en_q[k]    <= 1'b0;
        flt_extv_q[k]  <= 1'b0;
        flt_extdc_q[k] <= 1'b0;
        flt_id_q[k]    <= '0;
        flt_mask_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NFILT; k++) begin
        if (cs && we && (addr == 5'(16 + 2 * k))) begin
          flt_en_q[k]    <= d[31];
          flt_extv_q[k]  <= d[30];
          flt_extdc_q[k] <= d[29];
          flt_id_q[k]    <= d[28:0];
        end
        if (cs && we && (addr == 5'(17 + 2 * k)))
          flt_mask_q[k] <= d[28:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wp_q]     <= stg_q;
      mem_q[wp_q].hit <= hit_idx;
    end
  end

  always_comb begin
    q = '0;
    if (cs && !we) begin
      unique case (addr)
        5'd0: q = {ovr_cnt_q, 6'd0, ovr_flag_q, 5'(cnt_q), thresh_q,
                   full, empty, ovr_irq_en_q, irq_en_q, acc_all_q, 3'd0};
        5'd1: if (!empty) q = {head.ext, head.rtr, 1'b0, head.id};
        5'd2: if (!empty) q = {21'd0, head.hit, 4'd0, head.dlc};
        5'd3: if (!empty) q = head.data[31:0];
        5'd4: if (!empty) q = head.data[63:32];
        default: begin
          for (int k = 0; k < NFILT; k++) begin
            if (addr == 5'(16 + 2 * k))
              q = {flt_en_q[k], flt_extv_q[k], flt_extdc_q[k], flt_id_q[k]};
            if (addr == 5'(17 + 2 * k))
              q = {3'd0, flt_mask_q[k]};
          end
        end
      endcase
    end
  end

  assign thr = (thresh_q == 4'd0) ? 4'd1 : thresh_q;
  assign irq = (irq_en_q & (5'(cnt_q) >= {1'b0, thr})) |
               (ovr_irq_en_q & ovr_flag_q);

endmodule

// File: tb/tb_can_rx_filter_fifo.sv
// Directed bench for can_rx_filter_fifo: filters, FIFO order,
// overrun, interrupt threshold, flush and reset behaviour.
module tb_can_rx_filter_fifo;

  logic        clk, reset, cs, we;
  logic [4:0]  addr;
  logic [31:0] d, q;
  logic        in_valid, in_ext, in_rtr, irq;
  logic [28:0] in_id;
  logic [3:0]  in_dlc;
  logic [63:0] in_data;

  int n_chk, n_bad;
  logic [31:0] cfg;

  can_rx_filter_fifo #(.NFILT(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr),
    .d(d), .q(q), .in_valid(in_valid), .in_id(in_id),
    .in_ext(in_ext), .in_rtr(in_rtr), .in_dlc(in_dlc),
    .in_data(in_data), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chkr(input string tag, input logic [4:0] a,
                      input logic [31:0] exp);
    cs = 1'b1; we = 1'b0; addr = a;
    #1;
    chk(tag, q, exp);
    cs = 1'b0; addr = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; d = v;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; addr = '0; d = '0;
  endtask

  task automatic set_frame(input logic [28:0] id, input logic ext,
                           input logic rtr, input logic [3:0] dlc,
                           input logic [63:0] data);
    in_id = id; in_ext = ext; in_rtr = rtr;
    in_dlc = dlc; in_data = data;
  endtask

  task automatic send(input logic [28:0] id, input logic ext,
                      input logic rtr, input logic [3:0] dlc,
                      input logic [63:0] data);
    @(negedge clk);
    in_valid = 1'b1;
    set_frame(id, ext, rtr, dlc, data);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    reset = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; d = '0;
    in_valid = 1'b0;
    set_frame('0, 1'b0, 1'b0, '0, '0);
    #2;
    chk("rst_irq_async", {31'd0, irq}, 32'd0);
    #10 reset = 1'b0;
    tick();
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chkr("rst_stat", 5'd0, 32'h0000_0048);
    chkr("rst_head", 5'd1, 32'd0);
    chkr("rst_filt", 5'd16, 32'd0);
    chk("q_idle", q, 32'd0);

    // accept_all default: one frame, pushed one edge after capture
    send(29'h123, 1'b0, 1'b0, 4'd2, 64'hBEEF);
    chkr("t1_pre", 5'd0, 32'h0000_0048);
    tick();
    chkr("t1_stat", 5'd0, 32'h0000_1008);
    chkr("t1_id", 5'd1, 32'h0000_0123);
    chkr("t1_info", 5'd2, 32'h0000_0702);
    chkr("t1_d0", 5'd3, 32'h0000_BEEF);
    chkr("t1_d1", 5'd4, 32'h0000_0000);

    // filtering: filters 1 and 3 both accept 0x1FF, lowest wins
    cfg = 32'h0;
    wr(5'd0, cfg | 32'h1);
    wr(5'd18, 32'hA000_0100);
    wr(5'd19, 32'h0000_0700);
    wr(5'd22, 32'hA000_01FF);
    wr(5'd23, 32'h1FFF_FFFF);
    chkr("t2_fid", 5'd18, 32'hA000_0100);
    chkr("t2_fmask", 5'd19, 32'h0000_0700);
    wr(5'd24, 32'hFFFF_FFFF);
    chkr("t2_k4", 5'd24, 32'd0);
    chkr("t2_unmap", 5'd5, 32'd0);
    chkr("t2_empty_hd", 5'd3, 32'd0);
    send(29'h1FF, 1'b1, 1'b1, 4'd15, 64'h1122_3344_5566_7788);
    send(29'h200, 1'b0, 1'b0, 4'd1, 64'h0);
    tick();
    chkr("t2_stat", 5'd0, 32'h0000_1000);
    chkr("t2_id", 5'd1, 32'hC000_01FF);
    chkr("t2_info", 5'd2, 32'h0000_010F);
    chkr("t2_d0", 5'd3, 32'h5566_7788);
    chkr("t2_d1", 5'd4, 32'h1122_3344);
    wr(5'd0, cfg | 32'h1);
    wr(5'd18, 32'h0);
    wr(5'd22, 32'h0);

    // overrun: six frames into four entries
    cfg = 32'h28;
    wr(5'd0, cfg | 32'h2);
    for (int i = 0; i < 6; i++)
      send(29'(32'h11 + i), 1'b0, 1'b0, 4'd1, 64'(i));
    tick();
    chkr("t3_stat", 5'd0, 32'h0202_40A8);
    chk("t3_irq", {31'd0, irq}, 32'd1);
    chkr("t3_head", 5'd1, 32'h0000_0011);
    wr(5'd0, cfg | 32'h4);
    chkr("t3_clr", 5'd0, 32'h0000_40A8);
    chk("t3_irq_clr", {31'd0, irq}, 32'd0);

    // full: pop on the push edge keeps count and records no overrun
    @(negedge clk);
    in_valid = 1'b1;
    set_frame(29'h17, 1'b0, 1'b0, 4'd1, 64'h0);
    @(negedge clk);
    in_valid = 1'b0;
    cs = 1'b1; we = 1'b1; addr = 5'd0; d = cfg | 32'h1;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; d = '0;
    chkr("t4_stat", 5'd0, 32'h0000_40A8);
    chkr("t4_head", 5'd1, 32'h0000_0012);
    wr(5'd0, cfg | 32'h2);
    wr(5'd0, cfg | 32'h1);
    chkr("t4_empty_pop", 5'd0, 32'h0000_0068);

    // threshold interrupt
    cfg = 32'h318;
    wr(5'd0, cfg);
    send(29'h21, 1'b0, 1'b0, 4'd0, 64'h0);
    send(29'h22, 1'b0, 1'b0, 4'd0, 64'h0);
    tick();
    chk("t5_irq2", {31'd0, irq}, 32'd0);
    send(29'h23, 1'b0, 1'b0, 4'd0, 64'h0);
    tick();
    chk("t5_irq3", {31'd0, irq}, 32'd1);
    wr(5'd0, cfg | 32'h1);
    chk("t5_irq_pop", {31'd0, irq}, 32'd0);
    chkr("t5_stat", 5'd0, 32'h0000_2318);

    // back-to-back frames, flush on the second push edge
    @(negedge clk);
    in_valid = 1'b1;
    set_frame(29'h3A, 1'b0, 1'b0, 4'd1, 64'h0);
    @(negedge clk);
    set_frame(29'h3B, 1'b0, 1'b0, 4'd1, 64'h0);
    @(negedge clk);
    set_frame(29'h3C, 1'b0, 1'b0, 4'd1, 64'h0);
    cs = 1'b1; we = 1'b1; addr = 5'd0; d = cfg | 32'h2;
    @(negedge clk);
    in_valid = 1'b0;
    cs = 1'b0; we = 1'b0; d = '0;
    tick();
    chkr("t6_stat", 5'd0, 32'h0000_1318);
    chkr("t6_head", 5'd1, 32'h0000_003C);

    // reset while a frame sits in staging
    send(29'h55, 1'b0, 1'b0, 4'd1, 64'h0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    tick();
    chkr("t7_stat", 5'd0, 32'h0000_0048);
    chk("t7_irq", {31'd0, irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/can_rx_filter_fifo.md
# can_rx_filter_fifo

Parametrised receive buffer for the CAN controller family. It sits between a CAN receiver's frame-valid output and the CPU register bus. It applies up to NFILT programmable ID/mask acceptance filters and queues accepted frames in a DEPTH-entry FIFO, so software no longer loses frames while servicing the previous one. It also adds overrun counting and level-threshold interrupts, which the single-frame receiver lacks.

## Interface
- NFILT, 4: number of acceptance filters, 1..8.
- DEPTH, 4: FIFO entries, power of two, 2..16.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- cs  in  1  register access select.
- we  in  1  1 = write, 0 = read (qualified by cs).
- addr  in  5  word register index.
- d  in  32  write data.
- q  out  32  read data, combinational; 0 when cs=0 or we=1.
- in_valid  in  1  one-cycle pulse: receiver has a complete, CRC-good frame.
- in_id  in  29  frame ID; standard IDs are in [10:0].
- in_ext, in_rtr  in  1 each  IDE and RTR bits.
- in_dlc  in  4  DLC, stored raw (9..15 are not clipped).
- in_data  in  64  payload; byte0 is in [7:0].
- irq  out  1  level interrupt.

## Operation
- Register map:
  - 0 CTRL/STATUS
    - Write: d[0] pop, d[1] flush, d[2] clr_ovr (strobes); d[3] accept_all, d[4] irq_en, d[5] ovr_irq_en, d[11:8] thresh (stored).
    - Read: [3] accept_all, [4] irq_en, [5] ovr_irq_en, [6] empty, [7] full, [11:8] thresh, [16:12] count, [17] ovr_flag, [31:24] ovr_cnt, others 0.
  - 1 HEAD_ID: [31] ext, [30] rtr, [28:0] id.
  - 2 HEAD_INFO: [3:0] dlc, [10:8] hit index.
  - 3 HEAD_DATA0: bytes 0-3, byte0 in [7:0].
  - 4 HEAD_DATA1: bytes 4-7.
  - 16+2k FILT_ID k: [31] enable, [30] ext value, [29] ext don't-care, [28:0] id.
  - 17+2k FILT_MASK k: [28:0], 1 = compare that bit.
  - Unmapped addresses and filters k ≥ NFILT: read 0, writes ignored.
- Head registers read 0 when the FIFO is empty.
- Filter k matches when:
  - enable=1, and
  - ((in_id ^ id) & mask) == 0, and
  - (ext don't-care=1 or ext value == in_ext).
  - If several filters match, the lowest-index match wins and its index is stored as the hit index.
- If no filter matches and accept_all=1, the frame is accepted with hit index 7. Otherwise the frame is discarded silently and not counted.
- Entry content: id, ext, rtr, dlc, data, hit index (102 bits).
- Overrun: an accepted frame arriving with the FIFO full is dropped.
  - ovr_cnt increments, saturating at 255.
  - ovr_flag is set.
  - clr_ovr clears both.
- irq = (irq_en & count ≥ max(thresh,1)) | (ovr_irq_en & ovr_flag).
- Reset values:
  - count 0, pointers 0.
  - accept_all 1; irq_en, ovr_irq_en and thresh 0.
  - ovr_cnt 0, ovr_flag 0.
  - All filters: enable 0, id 0, mask 0.
  - irq 0, q 0.

## Timing
- Two-stage ingest:
  - Edge N (in_valid=1): frame is captured into a staging register.
  - Edge N+1: filter result is registered and the push occurs.
  - count and head reflect the new frame combinationally from edge N+1.
- in_valid may assert every cycle; full throughput, no backpressure.
- Register writes take effect at the cs&we edge. A filter change affects staged frames evaluated at later edges only.
- pop when empty: ignored.
- pop and push on the same edge: both occur and count is unchanged. This also applies when full, so no overrun is recorded.
- flush: pointers and count are cleared at that edge. A push on the same edge is discarded and does not count as overrun. Stored config is unaffected.
- Overrun and clr_ovr on the same edge: the clear wins, then the counter is set to 1 (the event is not lost).
- Pointers wrap modulo DEPTH. full = (count == DEPTH).
- Reset mid-ingest: the staged frame is lost and all state goes to reset values immediately.

## Test plan
- Reset, accept_all=1: send id 0x123, dlc 2, data 0xBEEF -> edge later count=1, HEAD_ID=0x123, HEAD_INFO=0x702, HEAD_DATA0=0xBEEF.
- accept_all=0, filter 1 = id 0x100, mask 0x700, ext don't-care: ids 0x1FF and 0x200 -> only 0x1FF is queued, with hit index 1.
- DEPTH=4, accept_all, 6 frames, no pops -> full=1, ovr_cnt=2, ovr_flag=1, head = frame 1. Then clr_ovr -> both 0.
- FIFO full: pop and push on the same edge -> count stays 4 and ovr_cnt is unchanged. FIFO empty: pop -> count stays 0.
- irq_en=1, thresh=3: push 2 frames -> irq=0. Push third frame -> irq=1. pop -> irq=0.
- Back-to-back in_valid for 3 cycles with flush on the second push edge -> count=1 afterwards, holding the third frame; ovr_cnt=0.
